bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). It sits directly upstream of the 3-digit ripple BCD adder and produces packed BCD operands for it. A binary value is accepted on a valid/ready handshake, converted over BIN_W shift cycles, and held on the output until consumed.

Parameters:
BIN_W, 10, width of the binary input in bits (>= 4).
DIGITS, 3, number of 4-bit BCD digits produced.

Ports:
clk  input  1  single clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  bin_in is valid.
in_ready  output  1  converter can accept a new value.
bin_in  input  BIN_W  unsigned binary value.
out_valid  output  1  bcd_out/ovf are valid and stable.
out_ready  input  1  downstream consumes the result.
bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) in bits [3:0], digit i in bits [4i+3:4i].
ovf  output  1  bin_in exceeded 10^DIGITS-1.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n); all state is cleared immediately on assertion, independent of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, bcd_out=0, ovf=0, shift count=0, binary shift register=0.
- FSM states and transitions:
  - IDLE: in_ready=1, out_valid=0. If in_valid is high at a clk edge:
    - capture bin_in into the binary shift register;
    - clear the BCD register;
    - ovf_r <= (bin_in > 10^DIGITS-1);
    - count <= BIN_W;
    - go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0. Each cycle:
    - every digit >= 5 gets +3 (4-bit, no carry out of the digit);
    - then the {BCD, binary} register shifts left by 1, with the binary MSB entering bit 0 of digit 0;
    - count decrements.
    - When count reaches 1 in this cycle, the final shift is performed and the FSM goes to DONE.
  - DONE: out_valid=1, in_ready=0, bcd_out/ovf held constant. If out_ready is high at a clk edge, go to IDLE. If out_ready stays low, hold indefinitely.
- Latency: input accepted at edge k; out_valid is high from edge k+BIN_W. Earliest next acceptance is edge k+BIN_W+2, giving throughput of one conversion per BIN_W+2 cycles.
- in_valid outside IDLE is ignored; the upstream must hold bin_in until in_ready.
- Overflow: the top digit's shifted-out bits are discarded, so bcd_out = bin_in mod 10^DIGITS (lower digits remain exact). ovf=1 flags truncation; it is registered with the data and valid only while out_valid=1.
- Digit invariant: every digit is always in 0..9 after any completed shift.
- Reset mid-SHIFT or mid-DONE: result is discarded, return to IDLE with reset values, no spurious out_valid.
- bcd_out maps directly onto the adder's A/B/C (or X/Y/Z) operand nibbles, ones digit to the least-significant stage.

Decomposition:
- Shared package/include holds:
  - state encoding constants: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - BCD_W=4;
  - a constant function computing 10^DIGITS-1 for the ovf compare.
- One natural sub-module: bcd_add3_cell, combinational, 4-bit in/out, out = (in >= 5) ? in+3 : in. Instantiated DIGITS times via generate.
- Count register width is $clog2(BIN_W+1).

Test Plan:
- Reset then bin_in=0, in_valid pulse: out_valid rises exactly 10 cycles after acceptance, bcd_out=12'h000, ovf=0.
- bin_in=255: bcd_out=12'h255, ovf=0. bin_in=999: bcd_out=12'h999, ovf=0.
- bin_in=1023: bcd_out=12'h023, ovf=1. bin_in=1000: bcd_out=12'h000, ovf=1.
- Backpressure: after conversion of 517, out_ready low for 5 cycles gives out_valid=1 and bcd_out=12'h517 stable throughout. in_valid asserted during this window is not accepted (in_ready=0). out_ready high returns to IDLE next edge.
- Reset mid-operation: assert rst_n=0 asynchronously 4 cycles into SHIFT. Outputs go to reset values immediately; after release, a new conversion of 64 gives 12'h064 with normal latency.
- Back-to-back chain: the outputs of two converters (123 and 876) feed the 3-digit BCD adder with cin=0, giving sum digits 999 and cout=0. With 124 and 876 the result is 000 and cout=1.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the FSM state encoding, the BCD digit width and a constant
// function giving the largest value representable in a number of digits.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int BCD_W = 4;

    // Largest decimal value that fits in 'digits' BCD digits (10^digits - 1).
    function automatic longint unsigned max_bcd_value(input int digits);
        longint unsigned v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3_cell: combinational "add 3 if >= 5" correction for one BCD
// digit, applied before each doubling step of the double-dabble algorithm.
// Ports:
//   digit_in  - current BCD digit (4 bits)
//   digit_out - corrected digit; wraps within 4 bits, no carry out
module bcd_add3_cell
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_W-1:0] digit_in,
    output logic [BCD_W-1:0] digit_out
);

    // Digits 5..9 become 8..12 so the following shift carries correctly.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_W'(5)) begin
            digit_out = digit_in + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential binary-to-BCD converter (double dabble).
// Accepts a binary value on a valid/ready handshake, performs BIN_W
// add-3/shift steps and holds the packed BCD result until consumed.
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   in_valid  - bin_in is valid
//   in_ready  - converter is idle and can accept a value
//   bin_in    - unsigned binary input
//   out_valid - bcd_out/ovf hold a finished result
//   out_ready - downstream consumes the result
//   bcd_out   - packed BCD, ones digit in bits [3:0]
//   ovf       - input exceeded 10^DIGITS-1 (result is input mod 10^DIGITS)
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        bin_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    ovf
);

    localparam int          BCD_TOT = BCD_W * DIGITS;
    localparam int          CNT_W   = $clog2(BIN_W + 1);
    localparam int          SR_W    = BCD_TOT + BIN_W;
    localparam logic [63:0] MAX_VAL = 64'(max_bcd_value(DIGITS));

    state_e               state_q, state_d;
    logic [BIN_W-1:0]     bin_q, bin_d;
    logic [BCD_TOT-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    logic [BCD_TOT-1:0]   bcd_adj;
    logic [SR_W-1:0]      shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3_cell u_add3 (
            .digit_in  (bcd_q[g*BCD_W +: BCD_W]),
            .digit_out (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // The top digit's outgoing bit falls off the end here, which is what
    // makes the result wrap to bin_in mod 10^DIGITS on overflow.
    assign shifted = {bcd_adj, bin_q} << 1;

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bin_d   = bin_in;
                    bcd_d   = '0;
                    ovf_d   = (64'(bin_in) > MAX_VAL);
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = shifted;
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq. Directed corner values plus
// random values are compared against a decimal-arithmetic reference model;
// handshake timing, backpressure, asynchronous reset and a behavioural
// BCD adder chain are exercised as well.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 10;
    localparam int DIGITS = 3;
    localparam int OUT_W  = 4 * DIGITS;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] bin_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] bcd_out;
    logic             ovf;

    int checks;
    int errors;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: decimal digits of value mod 10^DIGITS.
    function automatic logic [OUT_W-1:0] expected_bcd(input int value);
        logic [OUT_W-1:0] res;
        int r;
        int lim;
        lim = 1;
        for (int i = 0; i < DIGITS; i++) lim = lim * 10;
        r   = value % lim;
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return res;
    endfunction

    // Behavioural 3-digit BCD adder used for the chain scenario; returns {cout, sum}.
    function automatic logic [OUT_W:0] bcd_add(input logic [OUT_W-1:0] a,
                                                input logic [OUT_W-1:0] b,
                                                input logic cin);
        logic [OUT_W-1:0] sum;
        int c;
        int d;
        c = int'(cin);
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
            c = (d > 9) ? 1 : 0;
            sum[4*i +: 4] = 4'(d % 10);
        end
        return {c[0], sum};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Convert one value: handshake in, check latency and result, apply
    // 'hold' cycles of backpressure (optionally poking in_valid), then consume.
    task automatic applyStimulus(input int value, input int hold, input bit intrude,
                                 output logic [OUT_W-1:0] got);
        int lat;
        int waited;
        logic [OUT_W-1:0] exp_bcd;
        exp_bcd = expected_bcd(value);
        waited  = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        bin_in   = BIN_W'(value);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 60);
        checkOutput($sformatf("latency(%0d)", value), 32'(lat), 32'(BIN_W));
        checkOutput($sformatf("bcd(%0d)", value), 32'(bcd_out), 32'(exp_bcd));
        checkOutput($sformatf("ovf(%0d)", value), 32'(ovf), 32'(value > 999));
        got = bcd_out;
        if (intrude) begin
            in_valid = 1'b1;
            bin_in   = BIN_W'(300);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_valid", 32'(out_valid), 32'd1);
            checkOutput("hold_bcd", 32'(bcd_out), 32'(exp_bcd));
            checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("consumed_valid", 32'(out_valid), 32'd0);
        checkOutput("consumed_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [OUT_W-1:0] got_a;
        logic [OUT_W-1:0] got_b;
        logic [OUT_W:0]   sum;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bin_in    = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_bcd", 32'(bcd_out), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0,    0, 1'b0, got_a);
        applyStimulus(255,  1, 1'b0, got_a);
        applyStimulus(999,  0, 1'b0, got_a);
        applyStimulus(1023, 2, 1'b0, got_a);
        applyStimulus(1000, 0, 1'b0, got_a);
        applyStimulus(517,  5, 1'b1, got_a);
        @(negedge clk);
        checkOutput("no_intruder_accept", 32'(in_ready), 32'd1);

        // Asynchronous reset four cycles into a conversion.
        in_valid = 1'b1;
        bin_in   = BIN_W'(700);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_bcd", 32'(bcd_out), 32'd0);
        checkOutput("midrst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < BIN_W + 2; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        applyStimulus(64, 0, 1'b0, got_a);

        for (int n = 0; n < 20; n++) begin
            applyStimulus(int'($urandom_range(0, 1023)), int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), got_a);
        end

        // Chain: two conversions feed a BCD adder.
        applyStimulus(123, 0, 1'b0, got_a);
        applyStimulus(876, 0, 1'b0, got_b);
        sum = bcd_add(got_a, got_b, 1'b0);
        checkOutput("chain_sum_999", 32'(sum[OUT_W-1:0]), 32'h999);
        checkOutput("chain_cout_0", 32'(sum[OUT_W]), 32'd0);
        applyStimulus(124, 0, 1'b0, got_a);
        sum = bcd_add(got_a, got_b, 1'b0);
        checkOutput("chain_sum_000", 32'(sum[OUT_W-1:0]), 32'h000);
        checkOutput("chain_cout_1", 32'(sum[OUT_W]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
